// File: rtl/my_test_pattern_if.sv
// Video timing configuration and output bundle for my_test_pattern.
// master drives run request and timings; slave (the generator) drives video outputs.
interface my_test_pattern_if;
    logic        en;
    logic [11:0] h_total;
    logic [11:0] h_sync;
    logic [11:0] h_bporch;
    logic [11:0] h_res;
    logic [11:0] v_total;
    logic [11:0] v_sync;
    logic [11:0] v_bporch;
    logic [11:0] v_res;
    logic        busy;
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] data;

    modport master (
        output en, h_total, h_sync, h_bporch, h_res,
        output v_total, v_sync, v_bporch, v_res,
        input  busy, de, hs, vs, data
    );

    modport slave (
        input  en, h_total, h_sync, h_bporch, h_res,
        input  v_total, v_sync, v_bporch, v_res,
        output busy, de, hs, vs, data
    );
endinterface

// File: rtl/my_test_pattern.sv
// Programmable video timing and 8-bar colour generator on the pixel clock.
// Macro TP_SCROLL_EN: bar pattern scrolls right by one pixel per frame.
module my_test_pattern #(
    parameter logic HS_POL = 1'b1,
    parameter logic VS_POL = 1'b1
) (
    input  logic             pxl_clk,
    input  logic             rst,
    my_test_pattern_if.slave vid
);
    // state | meaning
    // IDLE  | counters held at 0, outputs at reset levels, waiting for en
    // RUN   | frame in progress; frame end restarts or returns to IDLE
    typedef enum logic {IDLE, RUN} state_t;
    state_t state_q, state_d;

    logic [11:0] h_cnt, v_cnt, h_last, v_last, h_sync, v_sync;
    logic [11:0] bar_w, last_w, bar_col, start_col, start_col_d, h_nxt;
    logic [13:0] h_start, h_end, v_start, v_end;
    logic [2:0]  bar_idx, start_idx, start_idx_d;
    logic        latch, run, busy_d;
    logic        h_wrap, v_wrap, frame_end, h_act, v_act, bar_done;
    logic        busy_q, de_q, hs_q, vs_q;
    logic [23:0] data_q;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 24'hFFFFFF;
            3'd1:    bar_colour = 24'hFFFF00;
            3'd2:    bar_colour = 24'h00FFFF;
            3'd3:    bar_colour = 24'h00FF00;
            3'd4:    bar_colour = 24'hFF00FF;
            3'd5:    bar_colour = 24'hFF0000;
            3'd6:    bar_colour = 24'h0000FF;
            default: bar_colour = 24'h000000;
        endcase
    endfunction

    assign h_wrap    = (h_cnt >= h_last);
    assign v_wrap    = (v_cnt >= v_last);
    assign frame_end = h_wrap && v_wrap;
    assign h_nxt     = h_wrap ? 12'd0 : h_cnt + 12'd1;
    assign h_act     = ({2'b00, h_cnt} >= h_start) && ({2'b00, h_cnt} < h_end);
    assign v_act     = ({2'b00, v_cnt} >= v_start) && ({2'b00, v_cnt} < v_end);
    // the last bar runs until the remainder pixels are used up
    assign bar_done  = (bar_idx == 3'd7) ? (bar_col + 12'd1 >= last_w)
                                         : (bar_col + 12'd1 >= bar_w);

    always_ff @(posedge pxl_clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        run     = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (vid.en) begin
                    state_d = RUN;
                    latch   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                run    = 1'b1;
                busy_d = 1'b1;
                if (frame_end) begin
                    if (vid.en) begin
                        latch = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
        endcase
    end

`ifdef TP_SCROLL_EN
    // start position of the first active pixel steps back one column per frame
    always_comb begin
        start_idx_d = start_idx;
        start_col_d = start_col;
        if (run && frame_end) begin
            if (start_col != 12'd0) begin
                start_col_d = start_col - 12'd1;
            end else if (start_idx == 3'd0) begin
                start_idx_d = 3'd7;
                start_col_d = last_w - 12'd1;
            end else begin
                start_idx_d = start_idx - 3'd1;
                start_col_d = bar_w - 12'd1;
            end
        end
    end

    always_ff @(posedge pxl_clk) begin
        if (rst) begin
            start_idx <= 3'd0;
            start_col <= 12'd0;
        end else begin
            start_idx <= start_idx_d;
            start_col <= start_col_d;
        end
    end
`else
    assign start_idx   = 3'd0;
    assign start_col   = 12'd0;
    assign start_idx_d = 3'd0;
    assign start_col_d = 12'd0;
`endif

    always_ff @(posedge pxl_clk) begin
        if (rst) begin
            h_cnt   <= 12'd0;
            v_cnt   <= 12'd0;
            h_last  <= 12'd0;
            v_last  <= 12'd0;
            h_sync  <= 12'd0;
            v_sync  <= 12'd0;
            h_start <= 14'd0;
            h_end   <= 14'd0;
            v_start <= 14'd0;
            v_end   <= 14'd0;
            bar_w   <= 12'd0;
            last_w  <= 12'd0;
            bar_idx <= 3'd0;
            bar_col <= 12'd0;
            busy_q  <= 1'b0;
            de_q    <= 1'b0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            data_q  <= 24'd0;
        end else begin
            busy_q <= busy_d;
            if (latch) begin
                h_last  <= (vid.h_total == 12'd0) ? 12'd0 : vid.h_total - 12'd1;
                v_last  <= (vid.v_total == 12'd0) ? 12'd0 : vid.v_total - 12'd1;
                h_sync  <= vid.h_sync;
                v_sync  <= vid.v_sync;
                h_start <= {2'b00, vid.h_sync} + {2'b00, vid.h_bporch};
                h_end   <= {2'b00, vid.h_sync} + {2'b00, vid.h_bporch} + {2'b00, vid.h_res};
                v_start <= {2'b00, vid.v_sync} + {2'b00, vid.v_bporch};
                v_end   <= {2'b00, vid.v_sync} + {2'b00, vid.v_bporch} + {2'b00, vid.v_res};
                bar_w   <= {3'b000, vid.h_res[11:3]};
                last_w  <= {3'b000, vid.h_res[11:3]} + {9'd0, vid.h_res[2:0]};
            end
            if (run) begin
                h_cnt  <= h_nxt;
                if (h_wrap) v_cnt <= v_wrap ? 12'd0 : v_cnt + 12'd1;
                hs_q   <= (h_cnt < h_sync) ? HS_POL : ~HS_POL;
                vs_q   <= (v_cnt < v_sync) ? VS_POL : ~VS_POL;
                de_q   <= h_act && v_act;
                data_q <= (h_act && v_act) ? bar_colour(bar_idx) : 24'd0;
            end else begin
                h_cnt  <= 12'd0;
                v_cnt  <= 12'd0;
                hs_q   <= ~HS_POL;
                vs_q   <= ~VS_POL;
                de_q   <= 1'b0;
                data_q <= 24'd0;
            end
            // bar tracker always describes the pixel currently in h_cnt
            if (latch) begin
                bar_idx <= start_idx_d;
                bar_col <= start_col_d;
            end else if (run) begin
                if ({2'b00, h_nxt} == h_start) begin
                    bar_idx <= start_idx;
                    bar_col <= start_col;
                end else if (h_act) begin
                    if (bar_done) begin
                        bar_idx <= bar_idx + 3'd1;
                        bar_col <= 12'd0;
                    end else begin
                        bar_col <= bar_col + 12'd1;
                    end
                end
            end
        end
    end

    assign vid.busy = busy_q;
    assign vid.de   = de_q;
    assign vid.hs   = hs_q;
    assign vid.vs   = vs_q;
    assign vid.data = data_q;
endmodule

// File: tb/tb_my_test_pattern.sv
// Bench for my_test_pattern: per-cycle scoreboard against a cycle-index model,
// plus table-driven small timings and hand-written 1024x768 / mid-frame sequences.
module tb_my_test_pattern;
    localparam logic HS_POL = 1'b1;
    localparam logic VS_POL = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    my_test_pattern_if vif();

    my_test_pattern #(.HS_POL(HS_POL), .VS_POL(VS_POL)) dut (
        .pxl_clk (clk),
        .rst     (rst),
        .vid     (vif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] data;
    } pix_t;

    typedef struct {
        int ht, hs, hbp, hres, vt, vs, vbp, vres;
        int frames;
        int de_per_frame;
    } vec_t;

    pix_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [23:0] bars [8];

    bit m_run = 1'b0;
    int m_k, m_ht, m_vt, m_hs, m_hbp, m_hres, m_vs, m_vbp, m_vres;

    function automatic void model_latch();
        m_ht   = (vif.h_total == 12'd0) ? 1 : int'(vif.h_total);
        m_vt   = (vif.v_total == 12'd0) ? 1 : int'(vif.v_total);
        m_hs   = int'(vif.h_sync);
        m_hbp  = int'(vif.h_bporch);
        m_hres = int'(vif.h_res);
        m_vs   = int'(vif.v_sync);
        m_vbp  = int'(vif.v_bporch);
        m_vres = int'(vif.v_res);
    endfunction

    // Compare what the last edge produced, then predict the next edge from k = cycles into frame.
    always @(negedge clk) begin
        pix_t act, exp_p;
        int   h, v, col, row, bar;
        if (sb_q.size() > 0) begin
            exp_p = sb_q.pop_front();
            act   = {vif.busy, vif.de, vif.hs, vif.vs, vif.data};
            checks++;
            if (act !== exp_p) begin
                errors++;
                $display("FAIL pixel @%0t: got busy=%b de=%b hs=%b vs=%b data=%h, want busy=%b de=%b hs=%b vs=%b data=%h",
                         $time, act.busy, act.de, act.hs, act.vs, act.data,
                         exp_p.busy, exp_p.de, exp_p.hs, exp_p.vs, exp_p.data);
            end
        end
        exp_p.busy = 1'b0;
        exp_p.de   = 1'b0;
        exp_p.hs   = !HS_POL;
        exp_p.vs   = !VS_POL;
        exp_p.data = 24'h0;
        if (rst) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            if (vif.en) begin
                model_latch();
                m_run = 1'b1;
                m_k = 0;
                exp_p.busy = 1'b1;
            end
        end else begin
            h = m_k % m_ht;
            v = m_k / m_ht;
            exp_p.hs = (h < m_hs) ? HS_POL : !HS_POL;
            exp_p.vs = (v < m_vs) ? VS_POL : !VS_POL;
            col = h - m_hs - m_hbp;
            row = v - m_vs - m_vbp;
            if (col >= 0 && col < m_hres && row >= 0 && row < m_vres) begin
                exp_p.de = 1'b1;
                bar = (m_hres >= 8) ? col / (m_hres / 8) : 7;
                if (bar > 7) bar = 7;
                exp_p.data = bars[bar];
            end
            exp_p.busy = 1'b1;
            if (m_k == m_ht * m_vt - 1) begin
                if (vif.en) begin
                    model_latch();
                    m_k = 0;
                end else begin
                    m_run = 1'b0;
                    exp_p.busy = 1'b0;
                end
            end else begin
                m_k++;
            end
        end
        sb_q.push_back(exp_p);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int ht, hs, hbp, hres, vt, vs, vbp, vres);
        vif.h_total  = 12'(ht);
        vif.h_sync   = 12'(hs);
        vif.h_bporch = 12'(hbp);
        vif.h_res    = 12'(hres);
        vif.v_total  = 12'(vt);
        vif.v_sync   = 12'(vs);
        vif.v_bporch = 12'(vbp);
        vif.v_res    = 12'(vres);
    endtask

    initial begin
        vec_t        vecs [5];
        int          offs [6];
        logic [23:0] cols [6];
        int          n, p, per, de_cnt;

        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        vecs[0] = '{20, 2, 3,  8, 10, 1, 2, 4, 2, 32};
        vecs[1] = '{16, 2, 3, 16,  8, 1, 1, 4, 1, 44};
        vecs[2] = '{ 0, 1, 0,  8,  5, 2, 0, 2, 1,  0};
        vecs[3] = '{12, 0, 0,  8,  6, 0, 0, 6, 1, 48};
        vecs[4] = '{30, 2, 2, 21,  4, 1, 1, 2, 1, 42};
        offs = '{0, 127, 128, 383, 640, 1023};
        cols = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'hFF0000, 24'h000000};

        vif.en = 1'b0;
        set_cfg(1200, 10, 16, 1024, 806, 6, 29, 768);
        rst = 1'b1;
        tick(2);
        check("reset busy", vif.busy, 0);
        check("reset de",   vif.de, 0);
        check("reset hs",   vif.hs, !HS_POL);
        check("reset vs",   vif.vs, !VS_POL);
        check("reset data", vif.data, 0);

        rst = 1'b0;
        vif.en = 1'b1;
        check("busy before start", vif.busy, 0);
        tick(1);
        check("busy one cycle after en", vif.busy, 1);

        n = 0;
        while (vif.de !== 1'b1 && n < 50000) begin
            tick(1);
            n++;
        end
        check("first de latency", n, 35 * 1200 + 26 + 1);
        p = 0;
        for (int i = 0; i < 6; i++) begin
            tick(offs[i] - p);
            p = offs[i];
            check($sformatf("line35 px%0d data", offs[i]), vif.data, cols[i]);
        end
        tick(1);
        check("line35 de after 1024 px", vif.de, 0);

        // reset mid-frame with en still high
        rst = 1'b1;
        tick(1);
        check("midframe reset busy", vif.busy, 0);
        check("midframe reset hs", vif.hs, !HS_POL);
        rst = 1'b0;
        vif.en = 1'b0;
        tick(5);
        check("idle busy", vif.busy, 0);
        check("idle de", vif.de, 0);

        for (int i = 0; i < 5; i++) begin
            set_cfg(vecs[i].ht, vecs[i].hs, vecs[i].hbp, vecs[i].hres,
                    vecs[i].vt, vecs[i].vs, vecs[i].vbp, vecs[i].vres);
            vif.en = 1'b1;
            tick(1);
            check($sformatf("vec%0d busy at start", i), vif.busy, 1);
            if (vecs[i].frames == 1) vif.en = 1'b0;
            per = ((vecs[i].ht == 0) ? 1 : vecs[i].ht) * ((vecs[i].vt == 0) ? 1 : vecs[i].vt);
            for (int f = 0; f < vecs[i].frames; f++) begin
                de_cnt = 0;
                for (int c = 0; c < per; c++) begin
                    tick(1);
                    if (vif.de === 1'b1) de_cnt++;
                    if (f == vecs[i].frames - 1 && c == per - 2)
                        check($sformatf("vec%0d busy before frame end", i), vif.busy, 1);
                end
                check($sformatf("vec%0d frame%0d de count", i, f), de_cnt, vecs[i].de_per_frame);
                if (f == vecs[i].frames - 2) vif.en = 1'b0;
            end
            check($sformatf("vec%0d busy after frame end", i), vif.busy, 0);
            tick(2);
        end

        // h_res change mid-frame takes effect only at the next frame
        set_cfg(20, 2, 3, 8, 6, 1, 1, 3);
        vif.en = 1'b1;
        tick(1);
        de_cnt = 0;
        for (int c = 0; c < 120; c++) begin
            tick(1);
            if (c == 30) vif.h_res = 12'd12;
            if (vif.de === 1'b1) de_cnt++;
        end
        check("hres change frame1 de count", de_cnt, 24);
        vif.en = 1'b0;
        de_cnt = 0;
        for (int c = 0; c < 120; c++) begin
            tick(1);
            if (vif.de === 1'b1) de_cnt++;
        end
        check("hres change frame2 de count", de_cnt, 36);
        check("hres change busy after end", vif.busy, 0);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
